div_iter_32: RTL
================

// Module: div_iter_32
// PURPOSE
//  Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit/cycle.
//  Inverse-direction companion to the carry-lookahead adders: each step is a trial subtract.
//  Sits in EX beside the ALU; pipeline stalls while busy; valid/ready on both sides.
// PARAMETERS
//  XLEN      32  operand/result width (only 32 supported; parameter sizes internals)
//  CNT_W      6  iteration counter width, >= clog2(XLEN+1)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  kill       in   1     abort current op (pipeline flush), sync
//  in_valid   in   1     operands/op present
//  in_ready   out  1     divider can accept (high only in IDLE)
//  op         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend   in   XLEN  rs1
//  divisor    in   XLEN  rs2
//  out_valid  out  1     result present, held until out_ready
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  quotient or remainder per op
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE: accept on in_valid&in_ready (cycle 0): latch op, |dividend|,|divisor| (signed ops
//   take two's-complement magnitude), record quotient sign = sign(a)^sign(b), rem sign = sign(a).
//  CALC: 32 cycles (1..32); rem={rem[30:0],q_msb}; trial = rem - divisor (33-bit, borrow);
//   borrow=0 -> rem=trial, q bit=1; else restore, q bit=0. Counter 31 down to 0.
//  FIX (cycle 33): negate quotient/remainder per recorded signs; select by op; register result.
//  DONE: out_valid=1 from cycle 34; result stable until out_ready; then IDLE, in_ready=1 next cycle.
//  Latency accept->out_valid = 34 cycles; throughput one op per >=35 cycles.
//  Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend (unmodified).
//  Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
//  |0x80000000| is 0x80000000 treated as unsigned 32-bit; no extra width needed.
//  kill: any state -> IDLE next cycle, out_valid=0, result retains last value; kill overrides
//   out_ready and in_valid in the same cycle (no accept while kill=1).
//  rst mid-operation: identical to reset values above; in-flight op discarded.
//  in_valid while busy: ignored (in_ready=0); operands must be held by source.
// CONFIGURATION
//  DIV_FAST_SPECIAL_EN defined: divide-by-zero and signed overflow skip CALC/FIX; IDLE -> DONE,
//   out_valid on cycle 1 after accept with the same results as above.
//  Undefined: special cases take full 34-cycle path; results identical (FIX forces them).
// STRUCTURE
//  Shared package div_pkg: op encodings (DIV_OP_DIV/DIVU/REM/REMU), state enum, XLEN constant.
//  One sub-module: div_sub_33 - 33-bit combinational trial subtractor (rem - divisor),
//   built from cla_16 slices with inverted divisor and cin=1; outputs diff and borrow.
//  Top holds FSM, counter, rem/quotient shift registers, sign fix-up, result register.
// TESTING
//  DIVU 100/7 -> out_valid exactly 34 cycles after accept, result 14; REMU same -> 2.
//  DIV -7/2 (0xFFFFFFF9,2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF (sign follows dividend).
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU x/0 -> 0xFFFFFFFF, REMU x/0 -> x;
//   with DIV_FAST_SPECIAL_EN these complete in 1 cycle.
//  out_ready held low 10 cycles after out_valid -> result stable, in_ready=0 throughout.
//  kill at cycle 15 of CALC -> IDLE next cycle, no out_valid; next op returns correct result;
//   rst asserted mid-CALC -> all outputs at reset values next cycle.
//  Random 10k ops vs reference model, all 4 ops, incl. 0, 1, -1, INT_MIN operands.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operand width, op encodings,
// FSM states and the 16-bit carry-lookahead slice used by the trial subtractor.
package div_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // 16-bit carry-lookahead add; returns {carry_out, sum}
  function automatic logic [16:0] cla_16(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[16], p ^ c[15:0]};
  endfunction

endpackage

// File: rtl/div_sub_33.sv
// 33-bit trial subtractor: minuend - subtrahend as minuend + ~subtrahend + 1,
// assembled from two 16-bit lookahead slices plus a final single-bit stage.
module div_sub_33
  import div_pkg::*;
(
  input  logic [32:0] minuend_i,
  input  logic [32:0] subtrahend_i,
  output logic [32:0] diff_o,
  output logic        borrow_o
);

  logic [32:0] sub_inv;
  logic [16:0] lo_sum;
  logic [16:0] hi_sum;
  logic        top_p;
  logic        top_cout;

  // Chained slices; carry-out of the top bit clear means the subtraction borrowed
  always_comb begin
    sub_inv  = ~subtrahend_i;
    lo_sum   = cla_16(minuend_i[15:0], sub_inv[15:0], 1'b1);
    hi_sum   = cla_16(minuend_i[31:16], sub_inv[31:16], lo_sum[16]);
    top_p    = minuend_i[32] ^ sub_inv[32];
    top_cout = (minuend_i[32] & sub_inv[32]) | (top_p & hi_sum[16]);
    diff_o   = {top_p ^ hi_sum[16], hi_sum[15:0], lo_sum[15:0]};
    borrow_o = ~top_cout;
  end

endmodule

// File: rtl/div_iter_32.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass
// CALC/FIX and complete one cycle after accept.
module div_iter_32
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = DIV_XLEN,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             signed_op_c, is_rem_c, a_neg_c, b_neg_c, dz_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic [XLEN-1:0]  q_fix_c, r_fix_c, fix_res_c;
  logic [XLEN:0]    shifted_c, diff_c;
  logic             borrow_c;

  // Incoming operand decode: signedness, magnitudes, divide-by-zero
  always_comb begin
    signed_op_c = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    is_rem_c    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    a_neg_c     = signed_op_c & dividend[XLEN-1];
    b_neg_c     = signed_op_c & divisor[XLEN-1];
    a_mag_c     = a_neg_c ? (~dividend + XLEN'(1)) : dividend;
    b_mag_c     = b_neg_c ? (~divisor + XLEN'(1)) : divisor;
    dz_c        = (divisor == '0);
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic            ovf_c;
  logic [XLEN-1:0] fast_res_c;

  // Early-out results for divide-by-zero and INT_MIN / -1
  always_comb begin
    ovf_c      = signed_op_c && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    fast_res_c = dz_c ? (is_rem_c ? dividend : '1)
                      : (is_rem_c ? '0 : dividend);
  end
`endif

  // Shift the next dividend bit into the partial remainder (33 bits wide so
  // divisors with the top bit set never lose the remainder MSB)
  always_comb begin
    shifted_c = {rem_q, quo_q[XLEN-1]};
  end

  div_sub_33 u_sub (
    .minuend_i   (shifted_c),
    .subtrahend_i({1'b0, dvsr_q}),
    .diff_o      (diff_c),
    .borrow_o    (borrow_c)
  );

  // Sign fix-up and op select; with a zero divisor the remainder path
  // already reconstructs the original dividend, only the quotient is forced
  always_comb begin
    q_fix_c = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    r_fix_c = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
    if (dz_q && !is_rem_q) begin
      fix_res_c = '1;
    end else begin
      fix_res_c = is_rem_q ? r_fix_c : q_fix_c;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    result_d    = result_q;
    is_rem_d    = is_rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (kill) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            is_rem_d   = is_rem_c;
            rem_d      = '0;
            quo_d      = a_mag_c;
            dvsr_d     = b_mag_c;
            q_neg_d    = a_neg_c ^ b_neg_c;
            r_neg_d    = a_neg_c;
            dz_d       = dz_c;
            cnt_d      = CNT_W'(XLEN - 1);
            in_ready_d = 1'b0;
            state_d    = ST_CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (dz_c || ovf_c) begin
              result_d    = fast_res_c;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
`endif
          end
        end
        ST_CALC: begin
          rem_d = XLEN'(borrow_c ? shifted_c : diff_c);
          quo_d = {quo_q[XLEN-2:0], ~borrow_c};
          if (cnt_q == '0) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FIX: begin
          result_d    = fix_res_c;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      result_q    <= '0;
      is_rem_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      result_q    <= result_d;
      is_rem_q    <= is_rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
